// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter
//   Shares this core's ring token among N_REQ local I/O units. The circulating
//   TOKEN slot is captured and granted round-robin to one requesting unit.
//   That unit may overwrite NULL slots for up to MAX_BURST slots, after which
//   the TOKEN is re-emitted downstream on the next NULL slot.
//
// Ports
//   clock, reset      ring clock, asynchronous active-low reset
//   whichCore         this core's number (source of the re-emitted token)
//   SlotTypeIn        slot type currently in this core's ring stage
//   wantsToken        per-unit level request, held until served
//   driveRingReq      per-unit "driving my ring outputs this cycle"
//   ringOutBus        per-unit slot data, unit i at [32i+31:32i]
//   slotTypeOutBus    per-unit slot type, unit i at [4i+3:4i]
//   sourceOutBus      per-unit source,    unit i at [4i+3:4i]
//   acquireToken      one-hot grant, combinational
//   DriveRing         ring stage takes RingOut/SlotTypeOut/SourceOut
//   RingOut, SlotTypeOut, SourceOut  muxed ring drive
//   tokenHeld         arbiter owns the token (HOLD or RELEASE)
//   protocolError     sticky: some unit drove without its acquire

// Per-unit gating: a unit's data reaches the mux only while it holds acquire
// and asks to drive; driving without acquire is flagged and otherwise ignored.
module ring_token_arbiter_lane (
  input  logic        acquire,
  input  logic        drive_req,
  input  logic [31:0] ring,
  input  logic [3:0]  slot_type,
  input  logic [3:0]  source,
  output logic        drive,
  output logic [31:0] ring_m,
  output logic [3:0]  type_m,
  output logic [3:0]  src_m,
  output logic        err
);
  assign drive  = acquire & drive_req;
  assign ring_m = drive ? ring      : 32'd0;
  assign type_m = drive ? slot_type : 4'd0;
  assign src_m  = drive ? source    : 4'd0;
  assign err    = drive_req & ~acquire;
endmodule

module ring_token_arbiter #(
  parameter int         N_REQ     = 4,
  parameter int         MAX_BURST = 8,
  parameter logic [3:0] TOKEN     = 4'd1,
  parameter logic [3:0] NULL      = 4'd7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         whichCore,
  input  logic [3:0]         SlotTypeIn,
  input  logic [N_REQ-1:0]   wantsToken,
  input  logic [N_REQ-1:0]   driveRingReq,
  input  logic [32*N_REQ-1:0] ringOutBus,
  input  logic [4*N_REQ-1:0] slotTypeOutBus,
  input  logic [4*N_REQ-1:0] sourceOutBus,
  output logic [N_REQ-1:0]   acquireToken,
  output logic               DriveRing,
  output logic [31:0]        RingOut,
  output logic [3:0]         SlotTypeOut,
  output logic [3:0]         SourceOut,
  output logic               tokenHeld,
  output logic               protocolError
);
  localparam int         IW       = $clog2(N_REQ);
  localparam logic [3:0] MAXB     = 4'(MAX_BURST);
  localparam bit         ONE_SHOT = (MAX_BURST == 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RELEASE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt, owner, owner_nxt, winner, idx;
  logic [3:0]      burst, burst_nxt;
  logic            win_found, is_tok, is_null;
  logic [N_REQ-1:0] win_oh, acq;
  logic            drv_null, drv_tok;

  // per-lane views of the flat buses
  logic [N_REQ-1:0][31:0] lane_ring;
  logic [N_REQ-1:0][3:0]  lane_type, lane_src, m_type, m_src;
  logic [N_REQ-1:0][31:0] m_ring;
  logic [N_REQ-1:0]       lane_drv, lane_err;

  assign is_tok  = (SlotTypeIn == TOKEN);
  assign is_null = (SlotTypeIn == NULL);

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    inc_mod = (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // Round-robin winner: first requester at or after rr_ptr.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N_REQ);
      if (!win_found && wantsToken[idx]) begin
        winner    = idx;
        win_found = 1'b1;
      end
    end
    win_oh         = '0;
    win_oh[winner] = win_found;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      burst         <= '0;
      protocolError <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
      burst  <= burst_nxt;
      if (|lane_err) protocolError <= 1'b1;
    end
  end

  // Next-state
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    burst_nxt  = burst;
    unique case (state)
      IDLE: if (|acq) begin
        owner_nxt  = winner;
        rr_ptr_nxt = inc_mod(winner);
        burst_nxt  = driveRingReq[winner] ? 4'd1 : 4'd0;
        state_nxt  = (driveRingReq[winner] && ONE_SHOT) ? RELEASE : HOLD;
      end
      HOLD: begin
        if (acq[owner] && driveRingReq[owner]) burst_nxt = burst + 4'd1;
        // leave on the same edge as the last permitted slot
        if (!wantsToken[owner] || burst_nxt >= MAXB) state_nxt = RELEASE;
      end
      RELEASE: if (is_null) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: grants and arbiter-generated slots. Held inactive during reset
  // so the ring sees reset values immediately, not at the next edge.
  always_comb begin
    acq      = '0;
    drv_null = 1'b0;
    drv_tok  = 1'b0;
    unique case (state)
      IDLE: if (is_tok && win_found) begin
        acq      = win_oh;
        // token slot must be consumed; fill with NULL if winner is silent
        drv_null = !driveRingReq[winner];
      end
      HOLD: acq[owner] = wantsToken[owner] & is_null & (burst < MAXB);
      RELEASE: drv_tok = is_null;
      default: ;
    endcase
    if (!reset) begin
      acq      = '0;
      drv_null = 1'b0;
      drv_tok  = 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_lane
      assign lane_ring[g] = ringOutBus[32*g +: 32];
      assign lane_type[g] = slotTypeOutBus[4*g +: 4];
      assign lane_src[g]  = sourceOutBus[4*g +: 4];
      ring_token_arbiter_lane u_lane (
        .acquire  (acq[g]),
        .drive_req(driveRingReq[g]),
        .ring     (lane_ring[g]),
        .slot_type(lane_type[g]),
        .source   (lane_src[g]),
        .drive    (lane_drv[g]),
        .ring_m   (m_ring[g]),
        .type_m   (m_type[g]),
        .src_m    (m_src[g]),
        .err      (lane_err[g])
      );
    end
  endgenerate

  // At most one lane is granted, so an OR of masked lanes is the mux.
  logic [31:0] or_ring;
  logic [3:0]  or_type, or_src;
  always_comb begin
    or_ring = '0;
    or_type = '0;
    or_src  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      or_ring = or_ring | m_ring[i];
      or_type = or_type | m_type[i];
      or_src  = or_src  | m_src[i];
    end
  end

  assign acquireToken = acq;
  assign DriveRing    = (|lane_drv) | drv_null | drv_tok;
  assign RingOut      = or_ring;
  assign SlotTypeOut  = drv_tok ? TOKEN : ((|lane_drv) ? or_type : NULL);
  assign SourceOut    = drv_tok ? whichCore : or_src;
  assign tokenHeld    = (state == HOLD) || (state == RELEASE);

endmodule
